// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM-controller signal bundle for sdram_arbiter.
// slave: arbiter side; master: requesters plus SDRAM controller side.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 25
) ();
  logic [2:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [7:0]        din0;
  logic [7:0]        din1;
  logic [7:0]        din2;
  logic [2:0]        we;
  logic [2:0]        ack;
  logic              err;
  logic [7:0]        dout;
  logic              cpu_wait;
  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0]        sdram_din;
  logic              sdram_rd;
  logic              sdram_we;
  logic [7:0]        sdram_dout;
  logic              sdram_ready;

  modport slave (
    input  req, addr0, addr1, addr2, din0, din1, din2, we,
    output ack, err, dout, cpu_wait,
    output sdram_addr, sdram_din, sdram_rd, sdram_we,
    input  sdram_dout, sdram_ready
  );

  modport master (
    output req, addr0, addr1, addr2, din0, din1, din2, we,
    input  ack, err, dout, cpu_wait,
    input  sdram_addr, sdram_din, sdram_rd, sdram_we,
    output sdram_dout, sdram_ready
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Three-port SDRAM arbiter, CPU highest priority; SDRAM_ARB_STARVE_GUARD_EN forces backup grants.
// Ack 3 cycles after IDLE sample (4-cycle grant spacing); requesters hold req until ack, timeout aborts.
module sdram_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 255
) (
  input logic            clk,
  input logic            reset,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_din;
  logic              r_we;
  logic [7:0]        r_tmo;
  logic [7:0]        r_dout;
  logic              r_err;

  logic [1:0]        w_win;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_din;
  logic              w_force;
  logic              w_tmo_hit;
  logic [2:0]        w_ack;
  logic              w_rd;
  logic              w_we;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LP_STARVE_LIM = 8'(STARVE_LIMIT);

  logic [7:0] r_starve;

  assign w_force = bus.req[2] && (r_starve >= LP_STARVE_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= 8'd0;
    end else if (!bus.req[2]) begin
      r_starve <= 8'd0;
    end else if (r_state == IDLE) begin
      // req[2] is high here, so a grant happens this cycle
      if (w_win == 2'd2)
        r_starve <= 8'd0;
      else if (r_starve != 8'hFF)
        r_starve <= r_starve + 8'd1;
    end
  end
`else
  assign w_force = 1'b0;
  wire [7:0] w_unused_starve_limit = 8'(STARVE_LIMIT);
`endif

  always_comb begin
    w_win = 2'd2;
    if (w_force)
      w_win = 2'd2;
    else if (bus.req[0])
      w_win = 2'd0;
    else if (bus.req[1])
      w_win = 2'd1;
  end

  always_comb begin
    w_addr = bus.addr0;
    w_din  = bus.din0;
    case (w_win)
      2'd1: begin
        w_addr = bus.addr1;
        w_din  = bus.din1;
      end
      2'd2: begin
        w_addr = bus.addr2;
        w_din  = bus.din2;
      end
      default: ;
    endcase
  end

  assign w_tmo_hit = (r_tmo == LP_TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ack  = 3'b000;
    w_rd   = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|bus.req)
          w_next = ISSUE;
      end
      ISSUE: begin
        w_rd   = ~r_we;
        w_we   = r_we;
        w_next = WAIT;
      end
      WAIT: begin
        if (bus.sdram_ready || w_tmo_hit)
          w_next = ACK;
      end
      ACK: begin
        w_ack  = 3'b001 << r_grant;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= 2'd0;
      r_addr  <= '0;
      r_din   <= 8'd0;
      r_we    <= 1'b0;
      r_tmo   <= 8'd0;
      r_dout  <= 8'hFF;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_grant <= w_win;
            r_addr  <= w_addr;
            r_din   <= w_din;
            r_we    <= bus.we[w_win];
          end
        end
        ISSUE: r_tmo <= 8'd0;
        WAIT: begin
          if (bus.sdram_ready) begin
            r_err <= 1'b0;
            if (!r_we)
              r_dout <= bus.sdram_dout;
          end else if (w_tmo_hit) begin
            r_err  <= 1'b1;
            r_dout <= 8'hFF;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address and write data are the holding registers, so they keep the last issued values
  assign bus.sdram_addr = r_addr;
  assign bus.sdram_din  = r_din;
  assign bus.sdram_rd   = w_rd;
  assign bus.sdram_we   = w_we;
  assign bus.ack        = w_ack;
  assign bus.err        = r_err;
  assign bus.dout       = r_dout;
  assign bus.cpu_wait   = bus.req[0] & ~w_ack[0];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter (STARVE_LIMIT=8, TIMEOUT=4); SDRAM model returns addr[7:0]^8'h5A.
// All stimulus and checking run in one process, stepping one clock per tick.
module tb_sdram_arbiter;
  localparam int AW = 25;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(AW)) bus ();

  sdram_arbiter #(
    .ADDR_W      (AW),
    .STARVE_LIMIT(8),
    .TIMEOUT     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]    port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          err;
    logic [7:0]    dout;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int last_strobe_cyc = 0;
  int n_rd = 0;
  int n_we = 0;
  logic       s_rd, s_we, s_cw;
  logic [2:0] s_ack;
  logic       rdy_en = 1'b1;
  logic       pend = 1'b0;
  logic       inj = 1'b0;
  logic [7:0] pdata = 8'h00;
  logic [7:0] m_dout = 8'hFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [1:0] port, input logic err);
    exp_t e;
    e.port = port;
    e.wr   = bus.we[port];
    e.err  = err;
    case (port)
      2'd0:    begin e.addr = bus.addr0; e.din = bus.din0; end
      2'd1:    begin e.addr = bus.addr1; e.din = bus.din1; end
      default: begin e.addr = bus.addr2; e.din = bus.din2; end
    endcase
    if (err)
      m_dout = 8'hFF;
    else if (!e.wr)
      m_dout = e.addr[7:0] ^ 8'h5A;
    e.dout = m_dout;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    s_rd  = bus.sdram_rd;
    s_we  = bus.sdram_we;
    s_ack = bus.ack;
    s_cw  = bus.cpu_wait;
    if (s_rd || s_we) begin
      last_strobe_cyc = cyc;
      if (s_rd) n_rd++;
      if (s_we) n_we++;
      if (sb.size() == 0) begin
        chk("strobe_unexp", 32'(sb.size()), 32'd1);
      end else begin
        chk("strobe_we", 32'(s_we), 32'(sb[0].wr));
        chk("strobe_rd", 32'(s_rd), 32'(!sb[0].wr));
        chk("sd_addr", 32'(bus.sdram_addr), 32'(sb[0].addr));
        if (sb[0].wr) chk("sd_din", 32'(bus.sdram_din), 32'(sb[0].din));
      end
      pend  = rdy_en;
      pdata = bus.sdram_addr[7:0] ^ 8'h5A;
    end
    if (s_ack != 3'b000) begin
      last_ack_cyc = cyc;
      if (sb.size() == 0) begin
        chk("ack_unexp", 32'(s_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(s_ack), 32'(3'b001 << e.port));
        chk("ack_err", 32'(bus.err), 32'(e.err));
        chk("ack_dout", 32'(bus.dout), 32'(e.dout));
      end
    end
    @(posedge clk);
    #1;
    bus.sdram_ready = pend | inj;
    bus.sdram_dout  = pend ? pdata : (inj ? 8'h77 : 8'h00);
    pend = 1'b0;
    inj  = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (s_ack == 3'b000 && n < budget);
    if (s_ack == 3'b000) chk("ack_wait", 32'(s_ack != 3'b000), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},  32'(bus.ack), 32'd0);
    chk({tag, "_err"},  32'(bus.err), 32'd0);
    chk({tag, "_dout"}, 32'(bus.dout), 32'hFF);
    chk({tag, "_rd"},   32'(bus.sdram_rd), 32'd0);
    chk({tag, "_we"},   32'(bus.sdram_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.sdram_addr), 32'd0);
    chk({tag, "_din"},  32'(bus.sdram_din), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    int acks[3];
    int rd0, we0;

    reset           = 1'b1;
    bus.req         = 3'b000;
    bus.we          = 3'b000;
    bus.addr0       = '0;
    bus.addr1       = '0;
    bus.addr2       = '0;
    bus.din0        = 8'h00;
    bus.din1        = 8'h00;
    bus.din2        = 8'h00;
    bus.sdram_ready = 1'b0;
    bus.sdram_dout  = 8'h00;
    #1;
    chk_reset_outputs("rst");
    chk("rst_cpu_wait", 32'(bus.cpu_wait), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // single CPU read with 1-cycle SDRAM response
    bus.addr0 = 25'h000100;
    bus.req   = 3'b001;
    push_exp(2'd0, 1'b0);
    n0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t1_cpu_wait%0d", k), 32'(s_cw), 32'(k < 3));
      chk($sformatf("t1_rd%0d", k), 32'(s_rd), 32'(k == 1));
    end
    chk("t1_ack_lat", 32'(last_ack_cyc - n0), 32'd3);
    chk("t1_strobe_lat", 32'(last_strobe_cyc - n0), 32'd1);
    bus.req = 3'b000;
    tick();

    // write path on port 1 at the top address
    bus.addr1 = 25'h1FFFFFF;
    bus.din1  = 8'hC3;
    bus.we    = 3'b010;
    bus.req   = 3'b010;
    rd0 = n_rd;
    we0 = n_we;
    push_exp(2'd1, 1'b0);
    wait_ack(20);
    bus.req = 3'b000;
    bus.we  = 3'b000;
    chk("t2_we_cycles", 32'(n_we - we0), 32'd1);
    chk("t2_rd_cycles", 32'(n_rd - rd0), 32'd0);
    tick();

    // fixed priority with all ports requesting
    bus.addr0 = 25'h000010;
    bus.addr1 = 25'h000021;
    bus.addr2 = 25'h000032;
    bus.req   = 3'b111;
    for (int k = 0; k < 3; k++) push_exp(2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_ack(20);
      acks[k] = last_ack_cyc;
    end
    chk("t3_spacing01", 32'(acks[1] - acks[0]), 32'd4);
    chk("t3_spacing12", 32'(acks[2] - acks[1]), 32'd4);
    bus.req[0] = 1'b0;
    push_exp(2'd1, 1'b0);
    push_exp(2'd2, 1'b0);
    wait_ack(20);
    bus.req[1] = 1'b0;
    wait_ack(20);
    bus.req = 3'b000;
    tick();

    // CPU and backup held continuously
    bus.addr0 = 25'h000055;
    bus.addr2 = 25'h0000AA;
    bus.req   = 3'b101;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 8; k++) push_exp(2'd0, 1'b0);
    push_exp(2'd2, 1'b0);
    for (int k = 0; k < 9; k++) wait_ack(20);
`else
    for (int k = 0; k < 12; k++) push_exp(2'd0, 1'b0);
    for (int k = 0; k < 12; k++) wait_ack(20);
`endif
    bus.req = 3'b000;
    tick();
    chk("t4_sb_drained", 32'(sb.size()), 32'd0);

    // timeout: backup read with no sdram_ready
    rdy_en    = 1'b0;
    bus.addr2 = 25'h000044;
    bus.req   = 3'b100;
    push_exp(2'd2, 1'b1);
    wait_ack(30);
    bus.req = 3'b000;
    chk("t5_tmo_lat", 32'(last_ack_cyc - last_strobe_cyc), 32'd5);
    tick();

    // reset during WAIT of a port-1 read
    bus.addr1 = 25'h0ABCDE;
    bus.req   = 3'b010;
    push_exp(2'd1, 1'b0);
    tick();
    tick();
    chk("t6_strobe", 32'(s_rd), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("t6_rst");
    sb.delete();
    m_dout  = 8'hFF;
    bus.req = 3'b000;
    tick();
    tick();
    reset = 1'b0;
    rd0   = n_rd;
    inj   = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_late_rdy_dout", 32'(bus.dout), 32'hFF);
    chk("t6_no_strobe", 32'(n_rd - rd0), 32'd0);
    rdy_en    = 1'b1;
    bus.addr0 = 25'h0001AB;
    bus.req   = 3'b001;
    push_exp(2'd0, 1'b0);
    n0 = cyc + 1;
    wait_ack(20);
    bus.req = 3'b000;
    chk("t6_ack_lat", 32'(last_ack_cyc - n0), 32'd3);
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
